// File: rtl/io_sw_debounce.sv
// Switch/key input conditioner: 2-FF synchroniser, tick-sampled per-bit debounce,
// and registered one-cycle rise/fall pulses on each debounced edge.
module io_sw_debounce #(
   parameter int WIDTH        = 32,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_sw_raw,
   output logic [WIDTH-1:0] o_io_sw,
   output logic [WIDTH-1:0] o_sw_rise,
   output logic [WIDTH-1:0] o_sw_fall,
   output logic             o_tick
);

   localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HIST_W = STABLE_TICKS - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             tick_reg;
   logic [WIDTH-1:0] sync1_reg;
   logic [WIDTH-1:0] sync2_reg;

   always_comb begin
      cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
   end

   // Tick is registered from the next count so it is high exactly while cnt_reg is at its last value.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt_reg  <= '0;
         tick_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         tick_reg <= (cnt_next == CNT_LAST);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= i_sw_raw;
         sync2_reg <= sync1_reg;
      end
   end

   assign o_tick = tick_reg;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [HIST_W-1:0] hist_reg;
         logic [HIST_W-1:0] hist_next;
         logic              level_reg;
         logic              rise_reg;
         logic              fall_reg;
         logic              run_high;
         logic              run_low;

         if (HIST_W == 1) begin : g_hist1
            assign hist_next = sync2_reg[gi];
         end else begin : g_histn
            assign hist_next = {hist_reg[HIST_W-2:0], sync2_reg[gi]};
         end

         // The current sample completes the run together with the stored history.
         assign run_high = (&hist_reg) & sync2_reg[gi];
         assign run_low  = ~(|hist_reg) & ~sync2_reg[gi];

         always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
               hist_reg  <= '0;
               level_reg <= 1'b0;
               rise_reg  <= 1'b0;
               fall_reg  <= 1'b0;
            end else begin
               rise_reg <= 1'b0;
               fall_reg <= 1'b0;
               if (tick_reg) begin
                  hist_reg <= hist_next;
                  if (run_high && !level_reg) begin
                     level_reg <= 1'b1;
                     rise_reg  <= 1'b1;
                  end else if (run_low && level_reg) begin
                     level_reg <= 1'b0;
                     fall_reg  <= 1'b1;
                  end
               end
            end
         end

         assign o_io_sw[gi]   = level_reg;
         assign o_sw_rise[gi] = rise_reg;
         assign o_sw_fall[gi] = fall_reg;
      end
   endgenerate

endmodule

// File: tb/tb_io_sw_debounce.sv
// Bench for io_sw_debounce: run-length reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_io_sw_debounce;
   localparam int WIDTH        = 32;
   localparam int TICK_DIV     = 4;
   localparam int STABLE_TICKS = 3;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] raw   = '0;
   logic [WIDTH-1:0] io_sw, sw_rise, sw_fall;
   logic             tick;

   always #5 clk = ~clk;

   io_sw_debounce #(
      .WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS)
   ) dut (
      .i_clk(clk), .i_reset(rst_n), .i_sw_raw(raw),
      .o_io_sw(io_sw), .o_sw_rise(sw_rise), .o_sw_fall(sw_fall), .o_tick(tick)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: raw delayed two clocks, tick on every TICK_DIV-th clock since release,
   // output follows any run of STABLE_TICKS equal samples.
   logic [WIDTH-1:0] m_d1 = '0, m_d2 = '0, m_out = '0, m_rise = '0, m_fall = '0;
   logic             m_tick = 1'b0;
   int               m_k = 0;
   logic             run_val [WIDTH];
   int               run_len [WIDTH];
   logic [WIDTH-1:0] smp;
   logic             was_tick;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_d1 = '0; m_d2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
            m_tick = 1'b0; m_k = 0;
            for (int b = 0; b < WIDTH; b++) begin
               run_val[b] = 1'b0;
               run_len[b] = 0;
            end
         end else begin
            was_tick = m_tick;
            smp      = m_d2;
            m_rise   = '0;
            m_fall   = '0;
            if (was_tick) begin
               for (int b = 0; b < WIDTH; b++) begin
                  if (smp[b] == run_val[b]) run_len[b]++;
                  else begin
                     run_val[b] = smp[b];
                     run_len[b] = 1;
                  end
                  if (run_len[b] >= STABLE_TICKS && run_val[b] != m_out[b]) begin
                     m_out[b] = run_val[b];
                     if (run_val[b]) m_rise[b] = 1'b1;
                     else            m_fall[b] = 1'b1;
                  end
               end
            end
            m_d2   = m_d1;
            m_d1   = raw;
            m_k++;
            m_tick = ((m_k % TICK_DIV) == TICK_DIV - 1);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check("cyc_io_sw", io_sw, m_out);
         check("cyc_rise", sw_rise, m_rise);
         check("cyc_fall", sw_fall, m_fall);
         check("cyc_tick", 32'(tick), 32'(m_tick));
      end
   end

   int first_k, rise_cnt, fall_cnt, hi_cnt, ticks, last_k, bad_space, wide;
   logic prev_tick, hit;

   initial begin
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // 1: reset mid-operation with all switches high
      raw = '1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (io_sw == '1) break;
      end
      check("t1_setup_high", io_sw, 32'hFFFF_FFFF);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t1_async_io_sw", io_sw, 32'h0);
      check("t1_async_rise", sw_rise, 32'h0);
      check("t1_async_fall", sw_fall, 32'h0);
      check("t1_async_tick", 32'(tick), 32'h0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("t1_tick_phase", 32'(tick), 32'((k % 4) == 3));
         if (k < 12) begin
            check("t1_no_early_rise", sw_rise, 32'h0);
            check("t1_io_still_low", io_sw, 32'h0);
         end else if (k == 12) begin
            check("t1_rise_at_3rd_tick", sw_rise, 32'hFFFF_FFFF);
            check("t1_io_high", io_sw, 32'hFFFF_FFFF);
         end else begin
            check("t1_rise_one_cycle", sw_rise, 32'h0);
            check("t1_io_held", io_sw, 32'hFFFF_FFFF);
         end
      end

      // 2: clean edge on bit 0
      raw = '0;
      repeat (20) @(negedge clk);
      check("t2_setup_low", io_sw, 32'h0);
      @(posedge clk);
      #2 raw = 32'h1;
      first_k = 0; rise_cnt = 0; fall_cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (sw_rise[0]) begin
            rise_cnt++;
            if (first_k == 0) first_k = k;
         end
         if (sw_fall != '0) fall_cnt++;
      end
      check("t2_rise_count", 32'(rise_cnt), 32'd1);
      check("t2_latency_le14", 32'(first_k >= 1 && first_k <= 14), 32'd1);
      check("t2_no_fall", 32'(fall_cnt), 32'd0);
      check("t2_io_bit0", io_sw, 32'h1);

      // 3: bounce on bit 5, then hold high
      hi_cnt = 0; rise_cnt = 0; first_k = 0;
      @(posedge clk);
      #2;
      for (int c = 0; c < 40; c++) begin
         raw[5] = (((c / 3) % 2) == 0);
         @(negedge clk);
         if (io_sw[5]) hi_cnt++;
         if (sw_rise[5]) rise_cnt++;
         @(posedge clk);
         #2;
      end
      raw[5] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (sw_rise[5]) begin
            rise_cnt++;
            if (first_k == 0) first_k = k;
         end
      end
      check("t3_low_during_bounce", 32'(hi_cnt), 32'd0);
      check("t3_single_rise", 32'(rise_cnt), 32'd1);
      check("t3_latency_le14", 32'(first_k >= 1 && first_k <= 14), 32'd1);
      check("t3_io_bit5", 32'(io_sw[5]), 32'd1);

      // 4: two-clock glitch on bit 7 placed between sample edges
      hit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (tick) begin
            hit = 1'b1;
            break;
         end
      end
      check("t4_tick_seen", 32'(hit), 32'd1);
      repeat (3) @(posedge clk);
      #2 raw[7] = 1'b1;
      repeat (2) @(posedge clk);
      #2 raw[7] = 1'b0;
      hi_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (io_sw[7] || sw_rise[7] || sw_fall[7]) hi_cnt++;
      end
      check("t4_bit7_quiet", 32'(hi_cnt), 32'd0);

      // 5: simultaneous rise on bit 0 and fall on bit 31
      @(posedge clk);
      #2 raw = 32'h8000_0000;
      repeat (30) @(negedge clk);
      check("t5_setup", io_sw, 32'h8000_0000);
      @(posedge clk);
      #2 raw = 32'h0000_0001;
      hit = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if ((sw_rise | sw_fall) != '0) begin
            hit = 1'b1;
            check("t5_rise", sw_rise, 32'h0000_0001);
            check("t5_fall", sw_fall, 32'h8000_0000);
            check("t5_io_sw", io_sw, 32'h0000_0001);
            @(negedge clk);
            check("t5_rise_end", sw_rise, 32'h0);
            check("t5_fall_end", sw_fall, 32'h0);
            break;
         end
      end
      check("t5_pulse_seen", 32'(hit), 32'd1);

      // 6: prescaler over 1000 clocks
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      ticks = 0; last_k = -1; bad_space = 0; wide = 0; prev_tick = 1'b0;
      for (int k = 1; k <= 1000; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (tick) begin
            ticks++;
            if (last_k >= 0 && (k - last_k) != 4) bad_space++;
            if (prev_tick) wide++;
            last_k = k;
         end
         prev_tick = tick;
      end
      check("t6_tick_count", 32'(ticks), 32'd250);
      check("t6_tick_spacing", 32'(bad_space), 32'd0);
      check("t6_tick_width", 32'(wide), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
